// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the core-memory access sequencer.
package mem_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEL,
    ST_READ,
    ST_REGEN,
    ST_DONE
  } seq_state_t;

  localparam int MOD_W = 2;
  localparam int SEC_W = 2;
  localparam int ADR_W = 8;
  localparam int CNT_W = 3;

  // Module index to select-line mapping (MZON, MTTN, MFFN, MSSN)
  localparam logic [MOD_W-1:0] MOD_ZO = 2'b00;
  localparam logic [MOD_W-1:0] MOD_TT = 2'b01;
  localparam logic [MOD_W-1:0] MOD_FF = 2'b10;
  localparam logic [MOD_W-1:0] MOD_SS = 2'b11;

  localparam int DEF_READ_CYC  = 2;
  localparam int DEF_REGEN_CYC = 2;

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Requester + core-memory bus bundle for mem_access_sequencer.
// DUPLEX_EN adds the partner sense word and the duplex mismatch pulse.
interface mem_access_sequencer_if #(
  parameter int WORD_W = 26
);
  import mem_seq_pkg::*;

  logic              ireq;
  logic [MOD_W-1:0]  imod;
  logic [SEC_W-1:0]  isec;
  logic [ADR_W-1:0]  iadr;
  logic              dreq;
  logic              dwe;
  logic [MOD_W-1:0]  dmod;
  logic [SEC_W-1:0]  dsec;
  logic [ADR_W-1:0]  dadr;
  logic [WORD_W-1:0] dwdata;
  logic [WORD_W-1:0] mdo_a;
  logic              ignt, dgnt, iack, dack;
  logic [WORD_W-1:0] rdata;
  logic              mzon, mttn, mffn, mssn;
  logic              secan, secbn;
  logic [ADR_W-1:0]  madr;
  logic              mrd, mwr;
  logic [WORD_W-1:0] mdi;
`ifdef DUPLEX_EN
  logic [WORD_W-1:0] mdo_b;
  logic              duperr;
`endif

  modport master (
`ifdef DUPLEX_EN
    output mdo_b, input duperr,
`endif
    output ireq, imod, isec, iadr, dreq, dwe, dmod, dsec, dadr, dwdata, mdo_a,
    input  ignt, dgnt, iack, dack, rdata, mzon, mttn, mffn, mssn,
    input  secan, secbn, madr, mrd, mwr, mdi
  );

  modport slave (
`ifdef DUPLEX_EN
    input mdo_b, output duperr,
`endif
    input  ireq, imod, isec, iadr, dreq, dwe, dmod, dsec, dadr, dwdata, mdo_a,
    output ignt, dgnt, iack, dack, rdata, mzon, mttn, mffn, mssn,
    output secan, secbn, madr, mrd, mwr, mdi
  );

endinterface

// File: rtl/mem_seq_arb.sv
// Two-way round-robin arbiter between instruction and data requesters.
module mem_seq_arb (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ireq,
  input  logic dreq,
  output logic gnt_i,
  output logic gnt_d
);

  // Starts as "data granted last" so the instruction side wins the first tie
  logic last_i_reg;

  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (en) begin
      if (ireq && dreq) begin
        gnt_i = ~last_i_reg;
        gnt_d = last_i_reg;
      end else begin
        gnt_i = ireq;
        gnt_d = dreq;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_i_reg <= 1'b0;
    end else if (gnt_i) begin
      last_i_reg <= 1'b1;
    end else if (gnt_d) begin
      last_i_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Core-memory cycle sequencer: arbitration, selects, destructive read, regenerate.
// Define DUPLEX_EN to drive the partner module in parallel and flag mismatches.
module mem_access_sequencer
  import mem_seq_pkg::*;
#(
  parameter int READ_CYC  = DEF_READ_CYC,
  parameter int REGEN_CYC = DEF_REGEN_CYC,
  parameter int WORD_W    = 26
) (
  input logic clk,
  input logic rst,
  mem_access_sequencer_if.slave bus
);

  seq_state_t        state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic              is_i_reg, we_reg;
  logic [MOD_W-1:0]  mod_reg;
  logic [SEC_W-1:0]  sec_reg;
  logic [ADR_W-1:0]  adr_reg;
  logic [WORD_W-1:0] wdata_reg, rd_a_reg;
  logic              arb_gi, arb_gd;
  logic              active, read_last;
  logic [3:0]        sel_n;

  mem_seq_arb u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (state_reg == ST_IDLE),
    .ireq  (bus.ireq),
    .dreq  (bus.dreq),
    .gnt_i (arb_gi),
    .gnt_d (arb_gd)
  );

  assign active    = (state_reg != ST_IDLE);
  assign read_last = (state_reg == ST_READ) && (cnt_reg == CNT_W'(READ_CYC - 1));

  always_comb begin
    state_next = state_reg;
    cnt_next   = '0;
    case (state_reg)
      ST_IDLE:  if (arb_gi || arb_gd) state_next = ST_SEL;
      ST_SEL:   state_next = ST_READ;
      ST_READ: begin
        if (read_last) state_next = ST_REGEN;
        else           cnt_next   = cnt_reg + 1'b1;
      end
      ST_REGEN: begin
        if (cnt_reg == CNT_W'(REGEN_CYC - 1)) state_next = ST_DONE;
        else                                  cnt_next   = cnt_reg + 1'b1;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
      is_i_reg  <= 1'b0;
      we_reg    <= 1'b0;
      mod_reg   <= '0;
      sec_reg   <= '0;
      adr_reg   <= '0;
      wdata_reg <= '0;
      rd_a_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (arb_gi || arb_gd) begin
        is_i_reg  <= arb_gi;
        we_reg    <= arb_gd & bus.dwe;
        mod_reg   <= arb_gi ? bus.imod : bus.dmod;
        sec_reg   <= arb_gi ? bus.isec : bus.dsec;
        adr_reg   <= arb_gi ? bus.iadr : bus.dadr;
        wdata_reg <= bus.dwdata;
      end
      if (read_last) rd_a_reg <= bus.mdo_a;
    end
  end

  // One active-low select per module; duplex also pulls the XOR-1 partner low
  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_sel
    localparam logic [MOD_W-1:0] GI = MOD_W'(gi);
`ifdef DUPLEX_EN
    assign sel_n[gi] = ~(active && (mod_reg[1] == GI[1]));
`else
    assign sel_n[gi] = ~(active && (mod_reg == GI));
`endif
  end

  assign bus.mzon  = sel_n[MOD_ZO];
  assign bus.mttn  = sel_n[MOD_TT];
  assign bus.mffn  = sel_n[MOD_FF];
  assign bus.mssn  = sel_n[MOD_SS];
  assign bus.secan = active ? ~sec_reg[0] : 1'b1;
  assign bus.secbn = active ? ~sec_reg[1] : 1'b1;
  assign bus.madr  = active ? adr_reg : '0;

  assign bus.ignt  = (state_reg == ST_SEL)  &&  is_i_reg;
  assign bus.dgnt  = (state_reg == ST_SEL)  && !is_i_reg;
  assign bus.iack  = (state_reg == ST_DONE) &&  is_i_reg;
  assign bus.dack  = (state_reg == ST_DONE) && !is_i_reg;
  assign bus.mrd   = (state_reg == ST_READ);
  assign bus.mwr   = (state_reg == ST_REGEN);
  assign bus.mdi   = bus.mwr ? (we_reg ? wdata_reg : rd_a_reg) : '0;
  assign bus.rdata = rd_a_reg;

`ifdef DUPLEX_EN
  logic [WORD_W-1:0] rd_b_reg;

  always_ff @(posedge clk) begin
    if (rst)            rd_b_reg <= '0;
    else if (read_last) rd_b_reg <= bus.mdo_b;
  end

  assign bus.duperr = (state_reg == ST_DONE) && (rd_a_reg != rd_b_reg);
`endif

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer: stimulus pushes expected grants/acks,
// a negedge monitor pops and compares them.
module tb_mem_access_sequencer;
  import mem_seq_pkg::*;

  localparam int WW = 26;
  localparam int RC = 2;
  localparam int WC = 2;
  localparam int LAST = 2 + RC + WC;

  typedef struct {
    bit          is_i;
    logic [WW-1:0] rdata;
    bit          duperr;
  } ack_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_access_sequencer_if #(.WORD_W(WW)) bus ();

  mem_access_sequencer #(
    .READ_CYC  (RC),
    .REGEN_CYC (WC),
    .WORD_W    (WW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  ack_t ack_q[$];
  bit   gnt_q[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] sel_now();
    return {bus.mssn, bus.mffn, bus.mttn, bus.mzon};
  endfunction

  // Monitor: compares grants and acks against the queued expectations
  always @(negedge clk) begin
    bit   eg;
    ack_t ea;
    if (!rst) begin
      if (bus.ignt || bus.dgnt) begin
        check("gnt_exclusive", {31'd0, bus.ignt & bus.dgnt}, 0);
        if (gnt_q.size() == 0) begin
          check("gnt_unexpected", 1, 0);
        end else begin
          eg = gnt_q.pop_front();
          check("gnt_who", {31'd0, bus.ignt}, {31'd0, eg});
        end
      end
      if (bus.iack || bus.dack) begin
        check("ack_exclusive", {31'd0, bus.iack & bus.dack}, 0);
        if (ack_q.size() == 0) begin
          check("ack_unexpected", 1, 0);
        end else begin
          ea = ack_q.pop_front();
          $display("[TB] ack %s rdata=0x%07h", bus.iack ? "I" : "D", bus.rdata);
          check("ack_who", {31'd0, bus.iack}, {31'd0, ea.is_i});
          check("ack_rdata", 32'(bus.rdata), 32'(ea.rdata));
`ifdef DUPLEX_EN
          check("ack_duperr", {31'd0, bus.duperr}, {31'd0, ea.duperr});
`endif
        end
      end
    end
  end

  // Full single transaction from an IDLE DUT with cycle-by-cycle strobe checks
  task automatic do_txn(input bit is_i, input logic [1:0] m, input logic [1:0] s,
                        input logic [7:0] a, input bit we, input logic [WW-1:0] wd,
                        input logic [WW-1:0] md, input logic [WW-1:0] emdi, input bit edup);
    logic [3:0] esel;
    logic [1:0] esec;
    esel = 4'hF;
    esel[m] = 1'b0;
`ifdef DUPLEX_EN
    esel[m ^ 2'b01] = 1'b0;
`endif
    esec = ~s;
    gnt_q.push_back(is_i);
    ack_q.push_back('{is_i, md, edup});
    bus.mdo_a = md;
    if (is_i) begin
      bus.ireq = 1'b1; bus.imod = m; bus.isec = s; bus.iadr = a;
    end else begin
      bus.dreq = 1'b1; bus.dmod = m; bus.dsec = s; bus.dadr = a;
      bus.dwe = we; bus.dwdata = wd;
    end
    for (int c = 1; c <= LAST; c++) begin
      tick();
      check("txn_mrd", {31'd0, bus.mrd}, {31'd0, (c >= 2 && c <= 1 + RC)});
      check("txn_mwr", {31'd0, bus.mwr}, {31'd0, (c >= 2 + RC && c <= 1 + RC + WC)});
      check("txn_sel", {28'd0, sel_now()}, {28'd0, esel});
      check("txn_sec", {30'd0, bus.secbn, bus.secan}, {30'd0, esec});
      check("txn_madr", {24'd0, bus.madr}, {24'd0, a});
      if (c >= 2 + RC && c <= 1 + RC + WC) check("txn_mdi", 32'(bus.mdi), 32'(emdi));
      check("txn_ack_cycle", {31'd0, is_i ? bus.iack : bus.dack}, {31'd0, c == LAST});
      if (c == LAST) begin
        bus.ireq = 1'b0; bus.dreq = 1'b0; bus.dwe = 1'b0;
      end
    end
    tick();
    check("idle_sel", {28'd0, sel_now()}, 32'hF);
    check("idle_madr", {24'd0, bus.madr}, 0);
  endtask

  task automatic wait_ack(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 30 && !got; i++) begin
      tick();
      if (bus.iack || bus.dack) got = 1'b1;
    end
    check(name, {31'd0, got}, 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    bus.ireq = 0; bus.imod = 0; bus.isec = 0; bus.iadr = 0;
    bus.dreq = 0; bus.dwe = 0; bus.dmod = 0; bus.dsec = 0; bus.dadr = 0;
    bus.dwdata = 0; bus.mdo_a = 0;
`ifdef DUPLEX_EN
    bus.mdo_b = 0;
`endif
    tick();
    tick();
    // Reset state while rst is still high
    check("rst_sel", {28'd0, sel_now()}, 32'hF);
    check("rst_sec", {30'd0, bus.secbn, bus.secan}, 32'h3);
    check("rst_strobes", {28'd0, bus.mrd, bus.mwr, bus.ignt | bus.dgnt, bus.iack | bus.dack}, 0);
    check("rst_madr", {24'd0, bus.madr}, 0);
    check("rst_mdi", 32'(bus.mdi), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    rst = 1'b0;
    tick();

    // Lone instruction fetch: module 2, sector 1
    do_txn(1'b1, 2'd2, 2'd1, 8'h35, 1'b0, '0, 26'h1234567, 26'h1234567, 1'b0);

    // Store returns the old word and writes the new one
    do_txn(1'b0, 2'd3, 2'd2, 8'hC4, 1'b1, 26'h3FFFFFF, 26'h0000001, 26'h3FFFFFF, 1'b0);

    // Three ties after reset alternate I, D, I
    do_reset();
    bus.mdo_a = 26'h0ABCDEF;
    bus.ireq = 1'b1; bus.imod = 2'd1; bus.isec = 2'd0; bus.iadr = 8'h10;
    bus.dreq = 1'b1; bus.dwe = 1'b0; bus.dmod = 2'd0; bus.dsec = 2'd3; bus.dadr = 8'h20;
    gnt_q.push_back(1'b1); gnt_q.push_back(1'b0); gnt_q.push_back(1'b1);
    ack_q.push_back('{1'b1, 26'h0ABCDEF, 1'b0});
    ack_q.push_back('{1'b0, 26'h0ABCDEF, 1'b0});
    ack_q.push_back('{1'b1, 26'h0ABCDEF, 1'b0});
    wait_ack("tie_ack1_timeout");
    wait_ack("tie_ack2_timeout");
    wait_ack("tie_ack3_timeout");
    bus.ireq = 1'b0; bus.dreq = 1'b0;
    tick();
    check("tie_idle_sel", {28'd0, sel_now()}, 32'hF);

    // Reset during READ aborts silently
    bus.mdo_a = 26'h2AAAAAA;
    bus.ireq = 1'b1; bus.imod = 2'd1; bus.isec = 2'd2; bus.iadr = 8'h80;
    gnt_q.push_back(1'b1);
    tick();
    tick();
    check("abort_in_read", {31'd0, bus.mrd}, 1);
    rst = 1'b1; bus.ireq = 1'b0;
    tick();
    check("abort_sel", {28'd0, sel_now()}, 32'hF);
    check("abort_mrd", {31'd0, bus.mrd}, 0);
    check("abort_ack", {31'd0, bus.iack | bus.dack}, 0);
    check("abort_madr", {24'd0, bus.madr}, 0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    do_txn(1'b1, 2'd1, 2'd2, 8'h80, 1'b0, '0, 26'h2AAAAAA, 26'h2AAAAAA, 1'b0);

    // IREQ withdrawn in DONE while DREQ stays up: only data gets the next grant
    bus.mdo_a = 26'h1111111;
    bus.dreq = 1'b1; bus.dwe = 1'b0; bus.dmod = 2'd3; bus.dsec = 2'd0; bus.dadr = 8'h11;
    bus.imod = 2'd0; bus.isec = 2'd0; bus.iadr = 8'h99;
    gnt_q.push_back(1'b0);
    ack_q.push_back('{1'b0, 26'h1111111, 1'b0});
    for (int i = 0; i < 4; i++) tick();
    bus.ireq = 1'b1;
    wait_ack("wd_ack1_timeout");
    bus.ireq = 1'b0;
    gnt_q.push_back(1'b0);
    ack_q.push_back('{1'b0, 26'h1111111, 1'b0});
    wait_ack("wd_ack2_timeout");
    bus.dreq = 1'b0;
    tick();
    tick();

`ifdef DUPLEX_EN
    // Partner pair 0/1 both selected; mismatch flags, equal words do not
    bus.mdo_b = 26'h0555555;
    do_txn(1'b0, 2'd0, 2'd0, 8'h42, 1'b0, '0, 26'h0AAAAAA, 26'h0AAAAAA, 1'b1);
    bus.mdo_b = 26'h0123456;
    do_txn(1'b0, 2'd0, 2'd0, 8'h43, 1'b0, '0, 26'h0123456, 26'h0123456, 1'b0);
`endif

    check("gnt_q_drained", gnt_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Sequences every core-memory cycle for the memory module register/sector select logic: arbitrates between the instruction-fetch requester and the data (operand load/store) requester, drives the active-low module and sector selects, and times the destructive read followed by the regenerate/write-back phase. It sits between the sequencer/HOP logic and the core memory modules and returns the fetched word with an acknowledge pulse.

## Interface
- READ_CYC, 2: cycles MRD is held high (destructive read); legal 1..7.
- REGEN_CYC, 2: cycles MWR is held high (regenerate or store); legal 1..7.
- WORD_W, 26: memory word width.
- CLK  in  1  single system clock; all state changes on rising edge.
- RST  in  1  synchronous, active-high reset.
- IREQ  in  1  instruction fetch request; held until IACK.
- IMOD, ISEC, IADR  in  2, 2, 8  instruction module, sector, word address.
- DREQ  in  1  data request; held until DACK.
- DWE  in  1  1 = store, 0 = load.
- DMOD, DSEC, DADR  in  2, 2, 8  data module, sector, word address.
- DWDATA  in  WORD_W  store data.
- MDO_A  in  WORD_W  sense data from the selected module.
- MDO_B  in  WORD_W  sense data from the partner module (DUPLEX_EN only).
- IGNT, DGNT  out  1  one-cycle grant pulses.
- IACK, DACK  out  1  one-cycle completion pulses.
- RDATA  out  WORD_W  read word, valid in the ACK cycle.
- MZON, MTTN, MFFN, MSSN  out  1  active-low module 0/2/4/6 select.
- SECAN, SECBN  out  1  active-low sector bits.
- MADR  out  8  word address to core.
- MRD, MWR  out  1  read and regenerate/write strobes.
- MDI  out  WORD_W  regenerate/write data.
- DUPERR  out  1  duplex mismatch pulse (DUPLEX_EN only).

## Operation
- States: IDLE, SEL, READ, REGEN, DONE.
- IDLE: no request pending → stay. Single request → grant it. Both pending → grant the requester not granted last; after reset, the instruction requester wins the first tie.
- Grant: latch requester, module, sector, address, DWE (forced 0 for instruction), DWDATA; go to SEL.
- SEL: 1 cycle; selects and MADR driven; go to READ.
- READ: READ_CYC cycles, MRD = 1; on the last cycle latch MDO_A into the read register; go to REGEN.
- REGEN: REGEN_CYC cycles, MWR = 1; MDI = DWDATA for a store, otherwise the latched read word; go to DONE.
- DONE: 1 cycle; ACK pulse to the latched requester; RDATA = latched word (a store also returns the old word); go to IDLE.
- Selects and MADR are held SEL through DONE and are inactive (high/0) in IDLE.
- A request withdrawn before its grant is dropped silently. Request inputs are ignored from grant to ACK.
- Module encode: 00→MZON, 01→MTTN, 10→MFFN, 11→MSSN. SECAN = ~sec[0], SECBN = ~sec[1].
- Reset values: state IDLE, last-grant = data, all selects 1, MRD/MWR/GNT/ACK/DUPERR 0, MADR/MDI/RDATA 0.
- RST mid-cycle: return to IDLE the next edge, no ACK. The in-flight core word is lost; this is accepted.

## Timing
- Request seen in IDLE at cycle t → GNT at t+1 (SEL), MRD t+2..t+1+READ_CYC, MWR the following REGEN_CYC cycles, ACK at t+2+READ_CYC+REGEN_CYC (t+6 with defaults).
- Earliest next grant is 1 cycle after DONE (IDLE sampling), so the back-to-back period is 7 cycles with defaults.
- GNT and ACK are registered, single-cycle, and mutually exclusive between requesters.

## Configuration
- DUPLEX_EN defined: the selected module and its partner (module index XOR 1) are both selected. Both sense words are latched, and DUPERR pulses in the DONE cycle if they differ. RDATA is taken from MDO_A. The regenerate phase writes both modules.
- Not defined: simplex operation. The MDO_B and DUPERR ports are absent.

## Structure
- Package mem_seq_pkg: state enum, module-encode constants, default READ_CYC/REGEN_CYC, address field widths.
- Sub-module mem_seq_arb: 2-way round-robin arbiter with last-grant flag, enabled only in IDLE.

## Test plan
- Lone IREQ, IMOD=2, ISEC=1, IADR=0x35, MDO_A=0x1234567 → IGNT t+1, MFFN=0 and SECAN=0 during SEL..DONE, MRD 2 cycles, MWR 2 cycles with MDI=0x1234567, IACK and RDATA=0x1234567 at t+6.
- IREQ and DREQ together three times → grants I, D, I; never both in one cycle.
- DREQ with DWE=1, DWDATA=0x3FFFFFF, MDO_A=0x0000001 → MDI=0x3FFFFFF during REGEN, RDATA=0x0000001 at DACK.
- RST asserted during READ → next cycle IDLE, all selects high, MRD=0, no ACK; a fresh IREQ completes normally.
- IREQ dropped in the IDLE cycle before grant while DREQ is pending → DGNT only, no IGNT.
- DUPLEX_EN, DMOD=0, MDO_A≠MDO_B → MZON=0 and MTTN=0, DUPERR=1 together with DACK, RDATA=MDO_A; with equal words DUPERR stays 0.
